// File: rtl/ula_pkg.sv
// ula_pkg: opcode constants and FSM state encoding shared by the multi-cycle ALU.
package ula_pkg;
   localparam logic [3:0] OP_SOMA = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_SHL  = 4'b0100;
   localparam logic [3:0] OP_SHR  = 4'b0101;
   typedef enum logic [1:0] {IDLE, CALC, FIM} state_t;
endpackage

// File: rtl/ula_divisor_seq.sv
// ula_divisor_seq: unsigned restoring divider, one quotient bit per cycle, done pulses after WIDTH cycles.
module ula_divisor_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic             done
);
   localparam int CW = $clog2(WIDTH + 1);
   logic [WIDTH-1:0] rem, d, diff;
   logic [WIDTH:0]   sh;
   logic [CW-1:0]    cnt;
   logic             ge;
   // quotient doubles as the dividend shift register
   assign sh   = {rem, quotient[WIDTH-1]};
   assign ge   = sh >= {1'b0, d};
   assign diff = sh[WIDTH-1:0] - d;
   always_ff @(posedge clk) begin
      if (rst) begin
         rem      <= '0;
         d        <= '0;
         quotient <= '0;
         cnt      <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem      <= '0;
            quotient <= dividend;
            d        <= divisor;
            cnt      <= CW'(WIDTH);
         end else if (cnt != '0) begin
            rem      <= ge ? diff : sh[WIDTH-1:0];
            quotient <= {quotient[WIDTH-2:0], ge};
            cnt      <= cnt - 1'b1;
            done     <= cnt == CW'(1);
         end
      end
   end
endmodule

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: multi-cycle ALU (add, sub, shift-add multiply, restoring divide, shifts)
// sequenced by an IDLE/CALC/FIM FSM with registered result, done pulse and error flag.
module ula_multiciclo
   import ula_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [3:0]         switchs,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic [2*WIDTH-1:0] saida,
   output logic               busy,
   output logic               done,
   output logic               erro
);
   localparam int CW = $clog2(WIDTH + 1);
   state_t             state, nxt;
   logic [3:0]         op;
   logic [2*WIDTH-1:0] a_r, acc, res;
   logic [WIDTH-1:0]   b_r, quo;
   logic [CW-1:0]      cnt;
   logic               accept, fin, div_done, err_c;
   assign accept = state == IDLE && start;
   assign busy   = state == CALC;
   ula_divisor_seq #(.WIDTH(WIDTH)) u_div (
      .clk(clk), .rst(rst), .start(accept && switchs == OP_DIV),
      .dividend(A), .divisor(B), .quotient(quo), .done(div_done)
   );
   always_ff @(posedge clk) state <= rst ? IDLE : nxt;
   always_comb begin
      nxt = state;
      fin = 1'b0;
      unique case (state)
         IDLE: nxt = start ? CALC : IDLE;
         CALC: if (op == OP_DIV ? div_done : cnt == '0) begin
            nxt = FIM;
            fin = 1'b1;
         end
         FIM:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   always_comb begin
      res   = '0;
      err_c = 1'b0;
      case (op)
         OP_SOMA: res = a_r + {{WIDTH{1'b0}}, b_r};
         OP_SUB:  res = a_r - {{WIDTH{1'b0}}, b_r};
         OP_MUL:  res = acc;
         OP_DIV:  begin
            res   = b_r == '0 ? '0 : {{WIDTH{1'b0}}, quo};
            err_c = b_r == '0;
         end
         OP_SHL:  res = {{WIDTH{1'b0}}, a_r[WIDTH-2:0], 1'b0};
         OP_SHR:  res = {{WIDTH{1'b0}}, 1'b0, a_r[WIDTH-1:1]};
         default: err_c = 1'b1;
      endcase
   end
   // a_r/b_r serve as multiplicand/multiplier shift registers during multiplication
   always_ff @(posedge clk) begin
      if (rst) begin
         op    <= '0;
         a_r   <= '0;
         b_r   <= '0;
         acc   <= '0;
         cnt   <= '0;
         saida <= '0;
         erro  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= fin;
         if (accept) begin
            op  <= switchs;
            a_r <= {{WIDTH{1'b0}}, A};
            b_r <= B;
            acc <= '0;
            cnt <= (switchs == OP_MUL || switchs == OP_DIV) ? CW'(WIDTH) : '0;
         end else if (state == CALC && cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (op == OP_MUL) begin
               if (b_r[0]) acc <= acc + a_r;
               a_r <= a_r << 1;
               b_r <= b_r >> 1;
            end
         end
         if (fin) begin
            saida <= res;
            erro  <= err_c;
         end
      end
   end
endmodule
